// File: rtl/vnu.sv
// Min-sum LDPC variable node unit: channel LLR + D check messages in, D extrinsic
// messages and a hard decision out. Two-stage pipeline, one update per cycle.
//
// Ports: clk, rst (async active-low), ld/llr (load channel LLR, arm init update),
//        en/r (accept D check messages), q/hd/vld (extrinsic msgs, hard decision),
//        iter (accepted updates since last ld, saturating).
// Optional: define VNU_HDCHG_EN to add hd_chg (hard decision changed flag).
module vnu #(
  parameter int D     = 3,
  parameter int res_w = 6,
  parameter int ext_w = 3,
  parameter int IT_W  = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld,
  input  logic [res_w-1:0]             llr,
  input  logic                         en,
  input  logic [res_w*D-1:0]           r,
  output logic [(res_w+ext_w)*D-1:0]   q,
  output logic                         hd,
  output logic                         vld,
`ifdef VNU_HDCHG_EN
  output logic                         hd_chg,
`endif
  output logic [IT_W-1:0]              iter
);

  localparam int data_w = res_w + ext_w;
  localparam int S      = data_w + 2;
  localparam int QMAX_I = 2 ** (data_w - 1) - 1;

  localparam logic signed [S-1:0] QMAX = S'(QMAX_I);
  localparam logic signed [S-1:0] QMIN = -QMAX;

  logic [res_w-1:0]        llr_q;
  logic                    init_q;

  logic [res_w-1:0]        l_eff;
  logic                    init_eff;
  logic signed [S-1:0]     r_ext [D];
  logic signed [S-1:0]     sum;

  logic                    s1_vld;
  logic                    s1_init;
  logic signed [S-1:0]     s1_total;
  logic signed [S-1:0]     s1_r [D];

  logic signed [S-1:0]     diff;
  logic signed [S-1:0]     clamp;
  logic [data_w*D-1:0]     q_nxt;

  // A load in the same cycle as en feeds the fresh llr straight in.
  assign l_eff    = ld ? llr : llr_q;
  assign init_eff = ld | init_q;

  // Init update ignores r entirely: total is the channel LLR alone.
  always_comb begin
    sum = {{(S-res_w){l_eff[res_w-1]}}, l_eff};
    for (int i = 0; i < D; i++) begin
      if (init_eff)
        r_ext[i] = '0;
      else
        r_ext[i] = {{(S-res_w){r[i*res_w+res_w-1]}},
                    r[i*res_w +: res_w]};
      sum = sum + r_ext[i];
    end
  end

  // Symmetric clamp keeps the most negative code out of the output.
  always_comb begin
    q_nxt = '0;
    diff  = '0;
    clamp = '0;
    for (int i = 0; i < D; i++) begin
      diff = s1_total - s1_r[i];
      if (diff > QMAX)
        clamp = QMAX;
      else if (diff < QMIN)
        clamp = QMIN;
      else
        clamp = diff;
      q_nxt[i*data_w +: data_w] = clamp[data_w-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      llr_q  <= '0;
      init_q <= 1'b1;
      iter   <= '0;
    end else begin
      if (ld)
        llr_q <= llr;
      if (en)
        init_q <= 1'b0;
      else if (ld)
        init_q <= 1'b1;
      if (ld)
        iter <= en ? IT_W'(1) : '0;
      else if (en && iter != {IT_W{1'b1}})
        iter <= iter + IT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld   <= 1'b0;
      s1_init  <= 1'b0;
      s1_total <= '0;
      for (int i = 0; i < D; i++)
        s1_r[i] <= '0;
    end else begin
      s1_vld <= en;
      if (en) begin
        s1_init  <= init_eff;
        s1_total <= sum;
        for (int i = 0; i < D; i++)
          s1_r[i] <= r_ext[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= 1'b0;
      q   <= '0;
      hd  <= 1'b0;
    end else begin
      vld <= s1_vld;
      if (s1_vld) begin
        q  <= q_nxt;
        hd <= s1_total[S-1];
      end
    end
  end

`ifdef VNU_HDCHG_EN
  // hd still holds the previous valid decision when this one lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      hd_chg <= 1'b0;
    else if (s1_vld)
      hd_chg <= s1_init ? 1'b0 : (s1_total[S-1] != hd);
  end
`endif

endmodule

// File: tb/tb_vnu.sv
// Scoreboard bench for vnu: a default instance and a narrow (ext_w=1)
// instance share stimulus; a monitor pops expected results on every vld.
module tb_vnu;

  localparam int D  = 3;
  localparam int RW = 6;
  localparam int WD = 9;
  localparam int WS = 7;

  logic            clk = 0;
  logic            rst = 0;
  logic            ld  = 0;
  logic [RW-1:0]   llr = '0;
  logic            en  = 0;
  logic [RW*D-1:0] r   = '0;

  logic [WD*D-1:0] q_d;
  logic            hd_d, vld_d;
  logic [5:0]      iter_d;
  logic [WS*D-1:0] q_s;
  logic            hd_s, vld_s;
  logic [5:0]      iter_s;
`ifdef VNU_HDCHG_EN
  logic            chg_d, chg_s;
`endif

  vnu u_def (
    .clk(clk), .rst(rst), .ld(ld), .llr(llr), .en(en), .r(r),
    .q(q_d), .hd(hd_d), .vld(vld_d),
`ifdef VNU_HDCHG_EN
    .hd_chg(chg_d),
`endif
    .iter(iter_d)
  );

  vnu #(.D(3), .res_w(6), .ext_w(1), .IT_W(6)) u_sat (
    .clk(clk), .rst(rst), .ld(ld), .llr(llr), .en(en), .r(r),
    .q(q_s), .hd(hd_s), .vld(vld_s),
`ifdef VNU_HDCHG_EN
    .hd_chg(chg_s),
`endif
    .iter(iter_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q[3];
    bit hd;
    bit chg;
  } exp_t;

  exp_t sb_d[$];
  exp_t sb_s[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int d0, input int d1, input int d2,
                      input int s0, input int s1, input int s2,
                      input bit h, input bit c);
    exp_t e;
    e.q[0] = d0; e.q[1] = d1; e.q[2] = d2;
    e.hd = h; e.chg = c;
    sb_d.push_back(e);
    e.q[0] = s0; e.q[1] = s1; e.q[2] = s2;
    sb_s.push_back(e);
  endtask

  task automatic push_same(input int a, input int b, input int c,
                           input bit h, input bit ch);
    push(a, b, c, a, b, c, h, ch);
  endtask

  // it_exp >= 0 checks iter (result of the previous edge) before driving.
  task automatic drive(input bit l, input int lv, input bit e,
                       input int a, input int b, input int c,
                       input int it_exp);
    @(negedge clk);
    if (it_exp >= 0) begin
      chk("iter_def", int'(iter_d), it_exp);
      chk("iter_sat", int'(iter_s), it_exp);
    end
    ld  = l;
    llr = RW'(lv);
    en  = e;
    r   = {RW'(c), RW'(b), RW'(a)};
  endtask

  task automatic idle(input int it_exp);
    drive(0, 0, 0, 0, 0, 0, it_exp);
  endtask

  // Monitor: compares each presented result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (vld_d) begin
        if (sb_d.size() == 0) begin
          chk("unexpected_vld_def", 1, 0);
        end else begin
          e = sb_d.pop_front();
          for (int i = 0; i < D; i++)
            chk($sformatf("q%0d_def", i),
                int'($signed(q_d[i*WD +: WD])), e.q[i]);
          chk("hd_def", int'(hd_d), int'(e.hd));
`ifdef VNU_HDCHG_EN
          chk("hd_chg_def", int'(chg_d), int'(e.chg));
`endif
        end
      end
      if (vld_s) begin
        if (sb_s.size() == 0) begin
          chk("unexpected_vld_sat", 1, 0);
        end else begin
          e = sb_s.pop_front();
          for (int i = 0; i < D; i++)
            chk($sformatf("q%0d_sat", i),
                int'($signed(q_s[i*WS +: WS])), e.q[i]);
          chk("hd_sat", int'(hd_s), int'(e.hd));
`ifdef VNU_HDCHG_EN
          chk("hd_chg_sat", int'(chg_s), int'(e.chg));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random traffic on the inputs.
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ld  = 1'($urandom);
      en  = 1'($urandom);
      llr = RW'($urandom);
      r   = (RW*D)'($urandom);
    end
    @(negedge clk);
    chk("rst_q_def", int'(q_d), 0);
    chk("rst_q_sat", int'(q_s), 0);
    chk("rst_hd", int'(hd_d), 0);
    chk("rst_vld", int'(vld_d), 0);
    chk("rst_iter", int'(iter_d), 0);
    ld = 0; en = 0;
    rst = 1;
    idle(-1); idle(-1); idle(0);

    // Init with llr=-5, r ignored; then extrinsic; hd sequence -5,+9,+3.
    drive(1, -5, 1, 9, 9, 9, -1);
    push_same(-5, -5, -5, 1, 0);
    drive(0, 0, 1, 10, -3, 7, 1);
    push_same(-1, 12, 2, 0, 1);
    drive(0, 0, 1, 4, 4, 0, 2);
    push_same(-1, -1, 3, 0, 0);

    // New load: first update never flags a change; then a 4-deep burst.
    drive(1, -7, 1, 5, 5, 5, 3);
    push_same(-7, -7, -7, 1, 0);
    drive(0, 0, 1, 1, 2, 3, 1);
    push_same(-2, -3, -4, 1, 0);
    drive(0, 0, 1, 10, 0, 0, 2);
    push_same(-7, 3, 3, 0, 1);
    drive(0, 0, 1, -1, -1, -1, 3);
    push_same(-9, -9, -9, 1, 1);
    drive(0, 0, 1, 2, 2, 3, 4);
    push_same(-2, -2, -3, 0, 1);

    // Saturation: data_w=7 instance clamps to +/-63.
    drive(1, 31, 1, 0, 0, 0, 5);
    push_same(31, 31, 31, 0, 0);
    drive(0, 0, 1, 31, 31, 31, 1);
    push(93, 93, 93, 63, 63, 63, 0, 0);
    drive(1, -32, 1, 0, 0, 0, 2);
    push_same(-32, -32, -32, 1, 0);
    drive(0, 0, 1, -32, -32, -32, 1);
    push(-96, -96, -96, -63, -63, -63, 1, 0);
    idle(2); idle(2); idle(2);

    // Reset with updates in flight: only the one already out is seen.
    drive(1, 1, 1, 0, 0, 0, -1);
    push_same(1, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 1, 1, 1);
    @(negedge clk);
    rst = 0; en = 0; ld = 0;
    @(negedge clk);
    chk("rst2_vld", int'(vld_d), 0);
    chk("rst2_iter", int'(iter_d), 0);
    chk("rst2_q", int'(q_d), 0);
    rst = 1;
    idle(0); idle(0); idle(0); idle(0);

    // iter saturation at 63.
    drive(1, 0, 1, 0, 0, 0, 0);
    push_same(0, 0, 0, 0, 0);
    for (int k = 1; k < 70; k++) begin
      drive(0, 0, 1, 0, 0, 0, (k > 63) ? 63 : k);
      push_same(0, 0, 0, 0, 0);
    end
    idle(63); idle(63); idle(63); idle(63);

    chk("sb_def_empty", sb_d.size(), 0);
    chk("sb_sat_empty", sb_s.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
